// File: rtl/tx_scramble_ctrl.sv
// Transmit scrambler controller: per-lane scramble enable, LFSR advance and LFSR reset
// for 8b/10b (Gen1/2) and 128b/130b (Gen3+), with data delayed one cycle to stay aligned.
module tx_scramble_ctrl #(
    parameter int unsigned BLOCK_SYMS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        turnOff,
    input  logic [2:0]  GEN,
    input  logic [5:0]  PIPEWIDTH,
    input  logic        txDataValid,
    input  logic [31:0] txData,
    input  logic [3:0]  txDataK,
    input  logic        txStartBlock,
    input  logic [1:0]  txSyncHeader,
    output logic [31:0] outData,
    output logic [3:0]  outDataK,
    output logic        outDataValid,
    output logic        outStartBlock,
    output logic [1:0]  outSyncHeader,
    output logic [3:0]  scramblingEnable,
    output logic [3:0]  advance,
    output logic        patternReset,
    output logic [1:0]  LFSRSel,
    output logic        blockAlignErr
);

    localparam int unsigned CNT_W = $clog2(BLOCK_SYMS);
    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] BLK_LEN  = SUM_W'(BLOCK_SYMS);
    localparam logic [SUM_W-1:0] LAST_SYM = SUM_W'(BLOCK_SYMS - 1);

    localparam logic [7:0] SYM_COM   = 8'hBC;
    localparam logic [7:0] SYM_SKP   = 8'h1C;
    localparam logic [7:0] ID_TS1    = 8'h1E;
    localparam logic [7:0] ID_TS2    = 8'h2D;
    localparam logic [7:0] ID_EIEOS  = 8'h00;
    localparam logic [7:0] ID_SKP_OS = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        OS_TS,
        OS_EIEOS,
        OS_SKP,
        OS_OTHER
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [3:0]         out_data_k_q, out_data_k_d;
    logic               out_valid_q, out_valid_d;
    logic               out_start_q, out_start_d;
    logic [1:0]         out_hdr_q, out_hdr_d;
    logic [3:0]         scr_en_q, scr_en_d;
    logic [3:0]         adv_q, adv_d;
    logic               pat_rst_q, pat_rst_d;
    logic               align_err_q, align_err_d;

    logic [3:0]         lane_mask;
    logic [SUM_W-1:0]   lane_bytes;
    logic [1:0]         lfsr_sel;
    state_e             blk_state;
    logic [CNT_W-1:0]   blk_cnt;
    logic [SUM_W-1:0]   blk_sum;
    logic [SUM_W-1:0]   sym_idx;

    // Lane configuration decoded from the PIPE width
    always_comb begin
        lane_mask  = 4'b1111;
        lane_bytes = SUM_W'(4);
        lfsr_sel   = 2'd2;
        case (PIPEWIDTH)
            6'd8: begin
                lane_mask  = 4'b0001;
                lane_bytes = SUM_W'(1);
                lfsr_sel   = 2'd0;
            end
            6'd16: begin
                lane_mask  = 4'b0011;
                lane_bytes = SUM_W'(2);
                lfsr_sel   = 2'd1;
            end
            default: ;
        endcase
    end

    assign LFSRSel = lfsr_sel;

    // Block tracking and per-lane control for the beat currently on the inputs
    always_comb begin
        state_d      = state_q;
        sym_cnt_d    = sym_cnt_q;
        out_data_d   = txData;
        out_data_k_d = txDataK;
        out_valid_d  = txDataValid;
        out_start_d  = txStartBlock;
        out_hdr_d    = txSyncHeader;
        scr_en_d     = '0;
        adv_d        = '0;
        pat_rst_d    = 1'b0;
        align_err_d  = 1'b0;
        blk_state    = state_q;
        blk_cnt      = sym_cnt_q;
        blk_sum      = '0;
        sym_idx      = '0;

        if (txDataValid) begin
            if (GEN >= 3'd3) begin
                // A start of block always wins; a mid-block start is flagged and restarts counting
                if (txStartBlock) begin
                    blk_cnt = '0;
                    if (sym_cnt_q != '0) begin
                        align_err_d = 1'b1;
                    end
                    case (txSyncHeader)
                        2'b01: blk_state = DATA;
                        2'b10: begin
                            case (txData[7:0])
                                ID_TS1, ID_TS2: blk_state = OS_TS;
                                ID_EIEOS:       blk_state = OS_EIEOS;
                                ID_SKP_OS:      blk_state = OS_SKP;
                                default:        blk_state = OS_OTHER;
                            endcase
                        end
                        default: begin
                            align_err_d = 1'b1;
                            blk_state   = OS_OTHER;
                        end
                    endcase
                end

                blk_sum = SUM_W'(blk_cnt) + lane_bytes;
                if (blk_sum >= BLK_LEN) begin
                    sym_cnt_d = '0;
                    state_d   = IDLE;
                    if (blk_state == IDLE) begin
                        align_err_d = 1'b1;
                    end
                end else begin
                    sym_cnt_d = blk_sum[CNT_W-1:0];
                    state_d   = blk_state;
                end

                for (int i = 0; i < 4; i++) begin
                    sym_idx = SUM_W'(blk_cnt) + SUM_W'(i);
                    if (lane_mask[i]) begin
                        case (blk_state)
                            DATA: begin
                                scr_en_d[i] = 1'b1;
                                adv_d[i]    = 1'b1;
                            end
                            OS_TS: begin
                                scr_en_d[i] = (sym_idx != '0);
                                adv_d[i]    = 1'b1;
                            end
                            OS_EIEOS: begin
                                adv_d[i] = 1'b1;
                                if (sym_idx == LAST_SYM) begin
                                    pat_rst_d = 1'b1;
                                end
                            end
                            OS_OTHER: adv_d[i] = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_mask[i]) begin
                        if (txDataK[i]) begin
                            if (txData[8*i +: 8] == SYM_COM) begin
                                pat_rst_d = 1'b1;
                            end
                            adv_d[i] = (txData[8*i +: 8] != SYM_SKP);
                        end else begin
                            scr_en_d[i] = 1'b1;
                            adv_d[i]    = 1'b1;
                        end
                    end
                end
            end

            // Bypass keeps the LFSR in reset and sends data in the clear
            if (turnOff) begin
                pat_rst_d = 1'b1;
                scr_en_d  = '0;
                adv_d     = lane_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sym_cnt_q    <= '0;
            out_data_q   <= '0;
            out_data_k_q <= '0;
            out_valid_q  <= 1'b0;
            out_start_q  <= 1'b0;
            out_hdr_q    <= '0;
            scr_en_q     <= '0;
            adv_q        <= '0;
            pat_rst_q    <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            out_data_q   <= out_data_d;
            out_data_k_q <= out_data_k_d;
            out_valid_q  <= out_valid_d;
            out_start_q  <= out_start_d;
            out_hdr_q    <= out_hdr_d;
            scr_en_q     <= scr_en_d;
            adv_q        <= adv_d;
            pat_rst_q    <= pat_rst_d;
            align_err_q  <= align_err_d;
        end
    end

    assign outData          = out_data_q;
    assign outDataK         = out_data_k_q;
    assign outDataValid     = out_valid_q;
    assign outStartBlock    = out_start_q;
    assign outSyncHeader    = out_hdr_q;
    assign scramblingEnable = scr_en_q;
    assign advance          = adv_q;
    assign patternReset     = pat_rst_q;
    assign blockAlignErr    = align_err_q;

endmodule

// File: tb/tb_tx_scramble_ctrl.sv
// Directed bench for tx_scramble_ctrl: Gen1/2 symbol rules, Gen3 block classes,
// alignment errors and turnOff bypass, checked with immediate assertions.
module tb_tx_scramble_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        turnOff;
    logic [2:0]  GEN;
    logic [5:0]  PIPEWIDTH;
    logic        txDataValid;
    logic [31:0] txData;
    logic [3:0]  txDataK;
    logic        txStartBlock;
    logic [1:0]  txSyncHeader;
    logic [31:0] outData;
    logic [3:0]  outDataK;
    logic        outDataValid;
    logic        outStartBlock;
    logic [1:0]  outSyncHeader;
    logic [3:0]  scramblingEnable;
    logic [3:0]  advance;
    logic        patternReset;
    logic [1:0]  LFSRSel;
    logic        blockAlignErr;

    int checks = 0;
    int errors = 0;

    tx_scramble_ctrl #(.BLOCK_SYMS(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .turnOff          (turnOff),
        .GEN              (GEN),
        .PIPEWIDTH        (PIPEWIDTH),
        .txDataValid      (txDataValid),
        .txData           (txData),
        .txDataK          (txDataK),
        .txStartBlock     (txStartBlock),
        .txSyncHeader     (txSyncHeader),
        .outData          (outData),
        .outDataK         (outDataK),
        .outDataValid     (outDataValid),
        .outStartBlock    (outStartBlock),
        .outSyncHeader    (outSyncHeader),
        .scramblingEnable (scramblingEnable),
        .advance          (advance),
        .patternReset     (patternReset),
        .LFSRSel          (LFSRSel),
        .blockAlignErr    (blockAlignErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat and move to just after the edge that registers it
    task automatic beat(input logic v, input logic [31:0] d, input logic [3:0] k,
                        input logic sb, input logic [1:0] hdr);
        txDataValid  = v;
        txData       = d;
        txDataK      = k;
        txStartBlock = sb;
        txSyncHeader = hdr;
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input logic [3:0] en, input logic [3:0] adv,
                       input logic pr, input logic err);
        check({tag, "_en"},  32'(scramblingEnable), 32'(en));
        check({tag, "_adv"}, 32'(advance),          32'(adv));
        check({tag, "_pr"},  32'(patternReset),     32'(pr));
        check({tag, "_err"}, 32'(blockAlignErr),    32'(err));
    endtask

    task automatic do_reset(input logic [2:0] g, input logic [5:0] w);
        reset = 1'b1;
        GEN = g;
        PIPEWIDTH = w;
        turnOff = 1'b0;
        beat(1'b0, 32'h0, 4'h0, 1'b0, 2'b00);
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset with live inputs
        reset = 1'b1;
        turnOff = 1'b0;
        GEN = 3'd1;
        PIPEWIDTH = 6'd32;
        txDataValid = 1'b1;
        txData = 32'h1234_5678;
        txDataK = 4'b0000;
        txStartBlock = 1'b1;
        txSyncHeader = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst_data",  outData, 32'h0);
            check("rst_valid", 32'(outDataValid), 32'h0);
            check("rst_start", 32'(outStartBlock), 32'h0);
            check("rst_hdr",   32'(outSyncHeader), 32'h0);
            ctl("rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        end
        check("lfsrsel_32", 32'(LFSRSel), 32'd2);
        reset = 1'b0;
        txStartBlock = 1'b0;
        txSyncHeader = 2'b00;
        @(posedge clk);
        #1;
        check("first_data",  outData, 32'h1234_5678);
        check("first_valid", 32'(outDataValid), 32'h1);
        ctl("first", 4'b1111, 4'b1111, 1'b0, 1'b0);

        // 2: Gen1 COM in lane3, SKP in lane2
        beat(1'b1, 32'hBC1C_55AA, 4'b1100, 1'b0, 2'b00);
        check("g1_k", 32'(outDataK), 32'(4'b1100));
        ctl("g1_comskp", 4'b0011, 4'b1011, 1'b1, 1'b0);
        beat(1'b0, 32'hFFFF_FFFF, 4'b1111, 1'b0, 2'b00);
        check("g1_idle_valid", 32'(outDataValid), 32'h0);
        ctl("g1_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // Gen2 W=16: other K in lane0, upper lanes masked
        do_reset(3'd2, 6'd16);
        check("lfsrsel_16", 32'(LFSRSel), 32'd1);
        beat(1'b1, 32'hBC1C_44F7, 4'b1101, 1'b0, 2'b00);
        ctl("g2_mask", 4'b0010, 4'b0011, 1'b0, 1'b0);

        // 3: Gen3 W=32 data block
        do_reset(3'd3, 6'd32);
        for (int b = 0; b < 4; b++) begin
            beat(1'b1, 32'hA5A5_0000 + 32'(b), 4'b0000, (b == 0), 2'b01);
            ctl($sformatf("g3_data%0d", b), 4'b1111, 4'b1111, 1'b0, 1'b0);
        end
        check("g3_cnt_wrap", 32'(dut.sym_cnt_q), 32'h0);
        beat(1'b1, 32'h0, 4'b0000, 1'b0, 2'b00);
        ctl("g3_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // 4: Gen3 W=8 TS1 block
        do_reset(3'd3, 6'd8);
        check("lfsrsel_8", 32'(LFSRSel), 32'd0);
        beat(1'b1, 32'hFFFF_FF1E, 4'b0000, 1'b1, 2'b10);
        ctl("ts_b0", 4'b0000, 4'b0001, 1'b0, 1'b0);
        for (int b = 1; b < 16; b++) begin
            beat(1'b1, 32'hFFFF_FF00 | 32'(b * 7), 4'b0000, 1'b0, 2'b00);
            ctl($sformatf("ts_b%0d", b), 4'b0001, 4'b0001, 1'b0, 1'b0);
        end
        beat(1'b1, 32'h0, 4'b0000, 1'b0, 2'b00);
        ctl("ts_after", 4'b0000, 4'b0000, 1'b0, 1'b0);

        // 5: Gen3 W=16 EIEOS then SKP
        do_reset(3'd3, 6'd16);
        for (int b = 0; b < 8; b++) begin
            beat(1'b1, (b == 0) ? 32'hFFFF_FF00 : 32'hFFFF_FFFF, 4'b0000, (b == 0), 2'b10);
            ctl($sformatf("eieos_b%0d", b), 4'b0000, 4'b0011, (b == 7), 1'b0);
        end
        for (int b = 0; b < 8; b++) begin
            beat(1'b1, (b == 0) ? 32'h0000_AAAA : 32'h0000_AAAA, 4'b0000, (b == 0), 2'b10);
            ctl($sformatf("skp_b%0d", b), 4'b0000, 4'b0000, 1'b0, 1'b0);
        end

        // 6: Gen3 W=32 restart at symbol 8, turnOff mid-block, bad header
        do_reset(3'd3, 6'd32);
        beat(1'b1, 32'h1111_1111, 4'b0000, 1'b1, 2'b01);
        ctl("al_d0", 4'b1111, 4'b1111, 1'b0, 1'b0);
        beat(1'b1, 32'h2222_2222, 4'b0000, 1'b0, 2'b00);
        ctl("al_d1", 4'b1111, 4'b1111, 1'b0, 1'b0);
        beat(1'b1, 32'h4A4A_4A1E, 4'b0000, 1'b1, 2'b10);
        check("al_start_out", 32'(outStartBlock), 32'h1);
        check("al_hdr_out", 32'(outSyncHeader), 32'(2'b10));
        ctl("al_restart", 4'b1110, 4'b1111, 1'b0, 1'b1);
        beat(1'b1, 32'h4A4A_4A4A, 4'b0000, 1'b0, 2'b00);
        ctl("al_ts1", 4'b1111, 4'b1111, 1'b0, 1'b0);
        turnOff = 1'b1;
        beat(1'b1, 32'h4A4A_4A4A, 4'b0000, 1'b0, 2'b00);
        ctl("turnoff", 4'b0000, 4'b1111, 1'b1, 1'b0);
        turnOff = 1'b0;
        beat(1'b1, 32'h4A4A_4A4A, 4'b0000, 1'b0, 2'b00);
        ctl("al_ts3", 4'b1111, 4'b1111, 1'b0, 1'b0);
        beat(1'b1, 32'h0000_0000, 4'b0000, 1'b1, 2'b00);
        ctl("bad_hdr", 4'b0000, 4'b1111, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_scramble_ctrl.md
Name: tx_scramble_ctrl

Overview:
Transmit-side scrambler controller, the TX mirror of the RX descrambler control. Sits between the TX framer/LTSSM ordered-set generator and the TX LFSR/scrambler, ahead of the PIPE TX interface. Tracks 8b/10b symbols (Gen1/2) or 128b/130b block position (Gen3+). Per byte lane it drives scramble enable, LFSR advance and LFSR reset, with data delayed to stay aligned.

Parameters:
BLOCK_SYMS, 16, symbols per 128b/130b block (fixed by protocol; exposed for bench shortening only)

Ports:
clk  in  1  PIPE clock, single clock domain
reset  in  1  synchronous, active-high
turnOff  in  1  LTSSM bypass: no scrambling, LFSR held in reset
GEN  in  3  link generation; <3 selects 8b/10b mode
PIPEWIDTH  in  6  8/16/32; valid byte lanes = PIPEWIDTH/8
txDataValid  in  1  beat qualifier
txData  in  32  symbols, lane0 = [7:0]
txDataK  in  4  per-lane K flag (Gen1/2)
txStartBlock  in  1  beat carries block symbol 0 (Gen3)
txSyncHeader  in  2  sync header, sampled with txStartBlock
outData  out  32  txData delayed 1 cycle
outDataK  out  4  txDataK delayed 1 cycle
outDataValid  out  1  txDataValid delayed 1 cycle
outStartBlock  out  1  txStartBlock delayed 1 cycle
outSyncHeader  out  2  header delayed 1 cycle
scramblingEnable  out  4  per-lane: XOR LFSR into this byte
advance  out  4  per-lane: LFSR steps for this byte
patternReset  out  1  LFSR reloads seed after this beat
LFSRSel  out  2  0/1/2 for PIPEWIDTH 8/16/other
blockAlignErr  out  1  one-cycle error pulse

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high.
- All outputs registered; 1-cycle latency from inputs. Control outputs align with the outData beat they act on.
- Reset: every output 0, state IDLE, symCnt 0.
- LFSRSel is combinational from PIPEWIDTH.
- Lane mask M = 4'b0001 / 4'b0011 / 4'b1111 for PIPEWIDTH 8 / 16 / 32. advance and scramblingEnable are always ANDed with M.
- txDataValid=0: symCnt and state hold; next-cycle advance=0, scramblingEnable=0, patternReset=0.
- turnOff=1 (overrides all modes): patternReset=1, scramblingEnable=0, advance=M. In Gen3, symCnt still tracks blocks.
- Gen1/2 (GEN<3), per valid lane i:
  - COM (0xBC, K=1) in any valid lane -> patternReset=1.
  - SKP (0x1C, K=1) -> advance[i]=0.
  - Any K symbol -> scramblingEnable[i]=0.
  - D symbol -> scramblingEnable[i]=1, advance[i]=1.
- Gen3 states: IDLE, DATA, OS_TS, OS_EIEOS, OS_SKP, OS_OTHER.
- symCnt counts 0..15 by bytes per valid beat and wraps to 0 after symbol 15.
- txStartBlock with valid, entry from any state:
  - header 01 -> DATA.
  - header 10 -> classify lane0 byte: 0x1E/0x2D -> OS_TS; 0x00 -> OS_EIEOS; 0xAA -> OS_SKP; else OS_OTHER.
  - header 00/11 -> blockAlignErr pulse, OS_OTHER.
- txStartBlock while symCnt!=0 -> blockAlignErr pulse, symCnt forced to 0, new block taken.
- symCnt wraps to 0 without txStartBlock -> blockAlignErr, state IDLE.
- Per-symbol rules within a block (symbol index = symCnt + lane):
  - DATA: enable=1, advance=1.
  - OS_TS: symbol 0 enable=0; symbols 1..15 enable=1; advance=1 on all symbols.
  - OS_EIEOS: enable=0, advance=1. The beat holding symbol 15 asserts patternReset=1.
  - OS_SKP: enable=0, advance=0 for the whole block.
  - OS_OTHER: enable=0, advance=1.
  - IDLE: enable=0, advance=0.
- Block completes (symbol 15 sent) with no new start -> IDLE.
- Changing GEN or PIPEWIDTH mid-block is illegal; the bench must apply reset afterwards.

Test Plan:
1. Reset held 3 cycles with activity on inputs -> all outputs 0 on each of those cycles. First valid beat after release appears one cycle later.
2. Gen1, W=32, txData=BC_1C_55_AA, K=1100 (lane3 COM, lane2 SKP) -> next cycle: patternReset=1, advance=1011, scramblingEnable=0011.
3. Gen3, W=32, header 01 with 4 beats -> scramblingEnable=1111 and advance=1111 on all 4 beats; symCnt back to 0; state IDLE afterwards.
4. Gen3, W=8, TS1 block (0x1E first) -> beat0 scramblingEnable=0001→0000 (enable 0), advance=0001. Beats 1..15 scramblingEnable=0001. Upper lanes stay 0.
5. Gen3, W=16, EIEOS block (8 beats) -> scramblingEnable=00 and advance=0011 throughout. patternReset=1 only on beat 8. SKP block (0xAA) gives advance=0000 on all beats.
6. Gen3, W=32, txStartBlock asserted at symCnt=8 -> blockAlignErr=1 for one cycle and new block classified. turnOff=1 mid-block -> patternReset=1, enable=0000, advance=1111.
